// File: rtl/rf_pkg.sv
// Shared types and helpers for the forest accumulator: FSM encoding, index-width
// helpers and saturating arithmetic used by the accumulator and the result path.
package rf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_ARGMAX = 3'd3,
    ST_PUSH   = 3'd4
  } state_t;

  // Bits needed to index n_labels labels; never narrower than one bit.
  function automatic int lbl_w(input int n_labels);
    return (n_labels > 1) ? $clog2(n_labels) : 1;
  endfunction

  // Bits needed for a pointer over n entries (channels or FIFO slots).
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Clamp a signed value into the two's-complement range of a w-bit word.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                   input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Increment an unsigned w-bit counter, sticking at its maximum.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/forest_accumulator_if.sv
// Host-facing bus of the forest accumulator: input channels, control pulses and
// the first-word-fall-through result port.
interface forest_accumulator_if #(
  parameter int N_DTPS     = 4,
  parameter int FIFO_WIDTH = 16
);
  logic                         i_is_clf;
  logic                         i_is_accum_fin;
  logic                         i_flush;
  logic [4:0]                   i_rgs_shift;
  logic [N_DTPS-1:0]            i_in_fifo_push;
  logic [N_DTPS*FIFO_WIDTH-1:0] i_in_fifo_rear;
  logic [N_DTPS-1:0]            o_in_fifo_is_full;
  logic                         i_out_pop;
  logic [FIFO_WIDTH-1:0]        o_out_front;
  logic                         o_out_vld;
  logic                         o_out_is_empty;
  logic                         o_busy;
  logic                         o_err;

  modport master (
    output i_is_clf, i_is_accum_fin, i_flush, i_rgs_shift,
           i_in_fifo_push, i_in_fifo_rear, i_out_pop,
    input  o_in_fifo_is_full, o_out_front, o_out_vld, o_out_is_empty,
           o_busy, o_err
  );

  modport slave (
    input  i_is_clf, i_is_accum_fin, i_flush, i_rgs_shift,
           i_in_fifo_push, i_in_fifo_rear, i_out_pop,
    output o_in_fifo_is_full, o_out_front, o_out_vld, o_out_is_empty,
           o_busy, o_err
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational front word; a pop and a push on a full
// FIFO in the same cycle both take effect. clr empties it like a reset.
module sync_fifo
  import rf_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] front,
  output logic             full,
  output logic             empty
);
  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign front   = mem[rd_ptr];

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; the empty flag gates every consumer of front.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/forest_accumulator.sv
// Collects tree-processor outputs from N_DTPS channels, votes (classification) or
// sums (regression) per sample, and queues one result word per sample.
module forest_accumulator
  import rf_pkg::*;
#(
  parameter int N_DTPS     = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int N_LABELS   = 4,
  parameter int IN_DEPTH   = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int ACC_WIDTH  = 24
) (
  input logic clk,
  input logic rst_n,
  forest_accumulator_if.slave bus
);
  localparam int LBL_W = lbl_w(N_LABELS);
  localparam int PW    = ptr_w(N_DTPS);

  state_t                        state;
  logic                          is_clf_q;
  logic [4:0]                    shift_q;
  logic                          clr;

  logic [N_DTPS-1:0]             in_empty;
  logic [N_DTPS-1:0]             in_full;
  logic [N_DTPS-1:0]             in_pop;
  logic [FIFO_WIDTH-1:0]         in_front [N_DTPS];

  logic [PW-1:0]                 rr_ptr;
  logic                          grant_vld;
  logic [PW-1:0]                 grant_idx;
  int                            cand;
  logic                          stage_vld;
  logic [FIFO_WIDTH-1:0]         stage_data;

  logic [ACC_WIDTH-1:0]          counters [N_LABELS];
  logic signed [ACC_WIDTH-1:0]   sum;
  logic [LBL_W-1:0]              scan_idx;
  logic [LBL_W-1:0]              best_idx;
  logic [ACC_WIDTH-1:0]          best_cnt;

  logic signed [63:0]            word_ext;
  logic signed [63:0]            sum_ext;
  logic                          lbl_ok;
  logic [LBL_W-1:0]              lbl;
  logic [FIFO_WIDTH-1:0]         result;
  logic                          out_push;
  logic                          out_full;
  logic                          out_empty;
  logic [FIFO_WIDTH-1:0]         out_front_raw;
  logic                          push_accepted;
  logic                          overflow;
  logic                          fin_bad;
  logic                          lbl_bad;

  assign clr = bus.i_flush;

  for (genvar k = 0; k < N_DTPS; k++) begin : g_in
    sync_fifo #(.WIDTH(FIFO_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .push     (bus.i_in_fifo_push[k]),
      .push_data(bus.i_in_fifo_rear[k*FIFO_WIDTH +: FIFO_WIDTH]),
      .pop      (in_pop[k]),
      .front    (in_front[k]),
      .full     (in_full[k]),
      .empty    (in_empty[k])
    );
  end

  sync_fifo #(.WIDTH(FIFO_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (out_push),
    .push_data(result),
    .pop      (bus.i_out_pop),
    .front    (out_front_raw),
    .full     (out_full),
    .empty    (out_empty)
  );

  // Round-robin search begins one channel past the last one served.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    in_pop    = '0;
    cand      = 0;
    if (state == ST_ACCUM || state == ST_DRAIN) begin
      for (int i = 1; i <= N_DTPS; i++) begin
        cand = (int'(rr_ptr) + i) % N_DTPS;
        if (!grant_vld && !in_empty[cand]) begin
          grant_vld = 1'b1;
          grant_idx = PW'(cand);
        end
      end
    end
    if (grant_vld) in_pop[grant_idx] = 1'b1;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rr_ptr     <= '0;
      stage_vld  <= 1'b0;
      stage_data <= '0;
    end else begin
      stage_vld <= grant_vld;
      if (grant_vld) begin
        rr_ptr     <= grant_idx;
        stage_data <= in_front[grant_idx];
      end
    end
  end

  assign word_ext = {{(64-FIFO_WIDTH){stage_data[FIFO_WIDTH-1]}}, stage_data};
  assign sum_ext  = {{(64-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum};
  assign lbl_ok   = {{(64-FIFO_WIDTH){1'b0}}, stage_data} < 64'(N_LABELS);
  assign lbl      = stage_data[LBL_W-1:0];

  assign result   = is_clf_q ? FIFO_WIDTH'(best_idx)
                             : FIFO_WIDTH'(sat_signed(sum_ext >>> shift_q, FIFO_WIDTH));
  assign out_push = (state == ST_PUSH) && !out_full;

  assign push_accepted = |(bus.i_in_fifo_push & (~in_full | in_pop));
  assign overflow      = |(bus.i_in_fifo_push & in_full & ~in_pop);
  assign fin_bad       = bus.i_is_accum_fin && (state != ST_IDLE) && (state != ST_ACCUM);
  assign lbl_bad       = stage_vld && is_clf_q && !lbl_ok;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      state     <= ST_IDLE;
      is_clf_q  <= 1'b0;
      shift_q   <= '0;
      sum       <= '0;
      scan_idx  <= '0;
      best_idx  <= '0;
      best_cnt  <= '0;
      bus.o_err <= 1'b0;
      for (int l = 0; l < N_LABELS; l++) counters[l] <= '0;
    end else begin
      if (overflow || fin_bad || lbl_bad) bus.o_err <= 1'b1;

      if (stage_vld) begin
        if (is_clf_q) begin
          if (lbl_ok) counters[lbl] <= ACC_WIDTH'(sat_inc(64'(counters[lbl]), ACC_WIDTH));
        end else begin
          sum <= ACC_WIDTH'(sat_signed(sum_ext + word_ext, ACC_WIDTH));
        end
      end

      case (state)
        ST_IDLE: begin
          // Words left behind while a result was waiting also open a sample.
          if (push_accepted || !(&in_empty) || bus.i_is_accum_fin) begin
            state    <= ST_ACCUM;
            is_clf_q <= bus.i_is_clf;
            shift_q  <= bus.i_rgs_shift;
          end
        end
        ST_ACCUM: begin
          if (bus.i_is_accum_fin) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (&in_empty && !stage_vld) begin
            state    <= is_clf_q ? ST_ARGMAX : ST_PUSH;
            scan_idx <= '0;
            best_idx <= '0;
            best_cnt <= '0;
          end
        end
        ST_ARGMAX: begin
          // Strict compare keeps the lowest index on ties.
          if (counters[scan_idx] > best_cnt) begin
            best_idx <= scan_idx;
            best_cnt <= counters[scan_idx];
          end
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LBL_W'(N_LABELS - 1)) state <= ST_PUSH;
        end
        ST_PUSH: begin
          if (!out_full) begin
            sum   <= '0;
            state <= ST_IDLE;
            for (int l = 0; l < N_LABELS; l++) counters[l] <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_in_fifo_is_full = in_full;
  assign bus.o_out_is_empty    = out_empty;
  assign bus.o_out_vld         = !out_empty;
  assign bus.o_out_front       = out_empty ? '0 : out_front_raw;
  assign bus.o_busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_forest_accumulator.sv
// Directed bench for forest_accumulator: voting, regression averaging, ties, bad
// labels, result back-pressure, input overflow, flush and mid-operation reset.
module tb_forest_accumulator;
  localparam int N_DTPS     = 4;
  localparam int FW         = 16;
  localparam int N_LABELS   = 4;
  localparam int IN_DEPTH   = 8;
  localparam int OUT_DEPTH  = 4;
  localparam int ACC_WIDTH  = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  forest_accumulator_if #(.N_DTPS(N_DTPS), .FIFO_WIDTH(FW)) bus ();

  forest_accumulator #(
    .N_DTPS(N_DTPS), .FIFO_WIDTH(FW), .N_LABELS(N_LABELS),
    .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic idle_inputs();
    bus.i_is_clf       = 1'b1;
    bus.i_is_accum_fin = 1'b0;
    bus.i_flush        = 1'b0;
    bus.i_rgs_shift    = 5'd0;
    bus.i_in_fifo_push = '0;
    bus.i_in_fifo_rear = '0;
    bus.i_out_pop      = 1'b0;
  endtask

  task automatic push4(input logic [3:0] mask, input logic [FW-1:0] w0, w1, w2, w3);
    bus.i_in_fifo_push = mask;
    bus.i_in_fifo_rear = {w3, w2, w1, w0};
    @(negedge clk);
    bus.i_in_fifo_push = '0;
  endtask

  task automatic pulse_fin();
    bus.i_is_accum_fin = 1'b1;
    @(negedge clk);
    bus.i_is_accum_fin = 1'b0;
  endtask

  task automatic pulse_flush();
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
  endtask

  task automatic pop1();
    bus.i_out_pop = 1'b1;
    @(negedge clk);
    bus.i_out_pop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.o_busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: o_busy still 1 after %0d cycles, required 0", tag, n);
    end
  endtask

  task automatic sample_clf(input logic [FW-1:0] label);
    bus.i_is_clf = 1'b1;
    push4(4'b0001, label, '0, '0, '0);
    pulse_fin();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.o_busy, bus.o_err, bus.o_out_is_empty, bus.o_out_vld} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_flags: busy/err/empty/vld=%b required 0010",
               {bus.o_busy, bus.o_err, bus.o_out_is_empty, bus.o_out_vld});
    end
    checks++;
    if ({bus.o_out_front, bus.o_in_fifo_is_full} !== 20'h0) begin
      failures++;
      $display("FAIL reset_data: front=%h full=%b required 0/0000",
               bus.o_out_front, bus.o_in_fifo_is_full);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clf_basic();
    int n;
    bus.i_is_clf = 1'b1;
    push4(4'b1111, 16'd2, 16'd2, 16'd1, 16'd3);
    push4(4'b0011, 16'd2, 16'd1, 16'd0, 16'd0);
    pulse_fin();
    n = 1;
    while (bus.o_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.o_busy || n > 14) begin
      failures++;
      $display("FAIL clf_latency: busy=%b cycles_after_fin=%0d required 0 within 14",
               bus.o_busy, n);
    end
    checks++;
    if (bus.o_out_vld !== 1'b1 || bus.o_out_front !== 16'd2) begin
      failures++;
      $display("FAIL clf_result: vld=%b front=%0d required 1/2", bus.o_out_vld, bus.o_out_front);
    end
    pop1();
  endtask

  task automatic test_rgs();
    bus.i_is_clf    = 1'b0;
    bus.i_rgs_shift = 5'd2;
    push4(4'b1111, 16'd100, 16'hFFEC, 16'd40, 16'd0);
    pulse_fin();
    wait_idle("rgs_avg");
    checks++;
    if (bus.o_out_front !== 16'd30) begin
      failures++;
      $display("FAIL rgs_avg: front=%0d required 30", bus.o_out_front);
    end
    pop1();
    bus.i_rgs_shift = 5'd0;
    push4(4'b1111, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    pulse_fin();
    wait_idle("rgs_sat");
    checks++;
    if (bus.o_out_front !== 16'h7FFF) begin
      failures++;
      $display("FAIL rgs_sat: front=%h required 7fff", bus.o_out_front);
    end
    pop1();
    checks++;
    if (bus.o_out_is_empty !== 1'b1) begin
      failures++;
      $display("FAIL rgs_empty: out_is_empty=%b required 1", bus.o_out_is_empty);
    end
  endtask

  task automatic test_tie();
    bus.i_is_clf = 1'b1;
    push4(4'b1111, 16'd0, 16'd3, 16'd3, 16'd0);
    pulse_fin();
    wait_idle("tie");
    checks++;
    if (bus.o_out_front !== 16'd0 || bus.o_out_vld !== 1'b1) begin
      failures++;
      $display("FAIL tie_result: vld=%b front=%0d required 1/0", bus.o_out_vld, bus.o_out_front);
    end
    pop1();
  endtask

  task automatic test_bad_label();
    bus.i_is_clf = 1'b1;
    push4(4'b0001, 16'd5, '0, '0, '0);
    repeat (4) @(negedge clk);
    checks++;
    if (bus.o_err !== 1'b1) begin
      failures++;
      $display("FAIL bad_label_err: err=%b required 1", bus.o_err);
    end
    pulse_fin();
    wait_idle("bad_label");
    checks++;
    if (bus.o_out_front !== 16'd0 || bus.o_out_vld !== 1'b1) begin
      failures++;
      $display("FAIL bad_label_result: vld=%b front=%0d required 1/0",
               bus.o_out_vld, bus.o_out_front);
    end
    pop1();
    pulse_flush();
    checks++;
    if (bus.o_err !== 1'b0) begin
      failures++;
      $display("FAIL flush_err_clear: err=%b required 0", bus.o_err);
    end
  endtask

  task automatic test_out_full();
    logic [FW-1:0] first_four [4];
    logic [FW-1:0] rest [4];
    first_four = '{16'd1, 16'd2, 16'd3, 16'd0};
    rest       = '{16'd2, 16'd3, 16'd0, 16'd2};
    for (int i = 0; i < OUT_DEPTH; i++) begin
      sample_clf(first_four[i]);
      wait_idle("out_fill");
    end
    sample_clf(16'd2);
    repeat (20) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_out_front !== 16'd1) begin
      failures++;
      $display("FAIL push_hold: busy=%b front=%0d required 1/1", bus.o_busy, bus.o_out_front);
    end
    pulse_fin();
    checks++;
    if (bus.o_err !== 1'b1) begin
      failures++;
      $display("FAIL fin_in_push_err: err=%b required 1", bus.o_err);
    end
    pop1();
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL push_release: busy=%b required 0 one cycle after pop", bus.o_busy);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.o_out_vld !== 1'b1 || bus.o_out_front !== rest[i]) begin
        failures++;
        $display("FAIL out_order[%0d]: vld=%b front=%0d required 1/%0d",
                 i, bus.o_out_vld, bus.o_out_front, rest[i]);
      end
      pop1();
    end
    pulse_flush();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < OUT_DEPTH; i++) begin
      sample_clf(16'd1);
      wait_idle("ovf_fill");
    end
    sample_clf(16'd1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < IN_DEPTH; i++) push4(4'b0010, '0, 16'd1, '0, '0);
    checks++;
    if (bus.o_in_fifo_is_full !== 4'b0010 || bus.o_err !== 1'b0) begin
      failures++;
      $display("FAIL in_fill: full=%b err=%b required 0010/0", bus.o_in_fifo_is_full, bus.o_err);
    end
    push4(4'b0010, '0, 16'd1, '0, '0);
    checks++;
    if (bus.o_err !== 1'b1) begin
      failures++;
      $display("FAIL in_overflow_err: err=%b required 1", bus.o_err);
    end
    pulse_flush();
    checks++;
    if ({bus.o_in_fifo_is_full, bus.o_out_is_empty, bus.o_err, bus.o_busy} !== 7'b0000100) begin
      failures++;
      $display("FAIL ovf_flush: full/empty/err/busy=%b required 0000100",
               {bus.o_in_fifo_is_full, bus.o_out_is_empty, bus.o_err, bus.o_busy});
    end
  endtask

  task automatic test_flush_mid();
    bus.i_is_clf = 1'b1;
    push4(4'b1111, 16'd3, 16'd3, 16'd3, 16'd3);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL accum_busy: busy=%b required 1", bus.o_busy);
    end
    pulse_flush();
    checks++;
    if ({bus.o_in_fifo_is_full, bus.o_out_is_empty, bus.o_err, bus.o_busy} !== 7'b0000100) begin
      failures++;
      $display("FAIL mid_flush: full/empty/err/busy=%b required 0000100",
               {bus.o_in_fifo_is_full, bus.o_out_is_empty, bus.o_err, bus.o_busy});
    end
    sample_clf(16'd1);
    wait_idle("post_flush");
    checks++;
    if (bus.o_out_front !== 16'd1) begin
      failures++;
      $display("FAIL post_flush_result: front=%0d required 1", bus.o_out_front);
    end
    pop1();
  endtask

  task automatic test_reset_mid();
    bus.i_is_clf = 1'b1;
    push4(4'b1111, 16'd2, 16'd2, 16'd2, 16'd2);
    pulse_fin();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.o_out_is_empty !== 1'b1 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: empty=%b busy=%b required 1/0", bus.o_out_is_empty, bus.o_busy);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_clf_basic();
    test_rgs();
    test_tie();
    test_bad_label();
    test_out_full();
    test_overflow();
    test_flush_mid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forest_accumulator.md
FOREST_ACCUMULATOR -- requirements
Module: forest_accumulator

Interface
REQ-001 SHALL have parameter N_DTPS, default 4: number of tree-processor input channels (1..16).
REQ-002 SHALL have parameter FIFO_WIDTH, default 16: input and result word width.
REQ-003 SHALL have parameter N_LABELS, default 4: classification labels (2..64); LBL_W = clog2(N_LABELS).
REQ-004 SHALL have parameter IN_DEPTH, default 8, and OUT_DEPTH, default 4: per-input and result FIFO depths (powers of two).
REQ-005 SHALL have parameter ACC_WIDTH, default 24: vote-counter and regression-sum width (> FIFO_WIDTH).
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk input 1 (rising edge), rst_n input 1.
REQ-007 SHALL have ports: i_is_clf in 1, mode (1 classification, 0 regression), sampled only in IDLE; i_is_accum_fin in 1, pulse closing the current sample; i_flush in 1, clear-all pulse; i_rgs_shift in 5, arithmetic right-shift for regression averaging.
REQ-008 SHALL have ports: i_in_fifo_push in N_DTPS; i_in_fifo_rear in N_DTPS*FIFO_WIDTH (channel k at bits k*FIFO_WIDTH +: FIFO_WIDTH); o_in_fifo_is_full out N_DTPS.
REQ-009 SHALL have ports: i_out_pop in 1; o_out_front out FIFO_WIDTH; o_out_vld out 1; o_out_is_empty out 1; o_busy out 1 (state != IDLE); o_err out 1 (sticky overflow).

Function
REQ-010 SHALL implement states IDLE, ACCUM, DRAIN, ARGMAX, PUSH.
REQ-011 IDLE->ACCUM on first accepted input push or on i_is_accum_fin; latches i_is_clf and i_rgs_shift.
REQ-012 ACCUM->DRAIN on i_is_accum_fin; DRAIN->ARGMAX (clf) or ->PUSH (rgs) when all input FIFOs are empty and the pipeline stage is idle.
REQ-013 Arbiter SHALL pop at most one non-empty input FIFO per cycle, round-robin starting one past the last served channel, in ACCUM and DRAIN only.
REQ-014 Popped word SHALL reach the accumulator one cycle after the pop (registered stage); push-to-accumulated latency is 2 cycles minimum.
REQ-015 Clf: counter[word[LBL_W-1:0]] += 1, saturating at 2^ACC_WIDTH-1; label >= N_LABELS SHALL be dropped and set o_err.
REQ-016 Rgs: sum += sign-extended word (two's complement), saturating at ACC_WIDTH signed limits.
REQ-017 ARGMAX SHALL scan one label per cycle (N_LABELS cycles); winner = highest count, ties go to lowest index; all-zero counts yield label 0.
REQ-018 PUSH: clf result = zero-extended winning label; rgs result = (sum >>> shift) saturated to FIFO_WIDTH signed range; written to the result FIFO, counters/sum cleared, then ->IDLE.
REQ-019 PUSH SHALL hold while the result FIFO is full; input FIFOs keep accepting pushes meanwhile.
REQ-020 Push into a full input FIFO SHALL be dropped and set o_err; a simultaneous pop and push on a full FIFO SHALL both succeed.
REQ-021 i_is_accum_fin outside IDLE/ACCUM SHALL be ignored and set o_err.
REQ-022 o_out_front/o_out_vld SHALL be first-word-fall-through: o_out_vld = !o_out_is_empty; pop when empty ignored.
REQ-023 i_flush SHALL, next cycle, empty all FIFOs, clear counters, sum, arbiter pointer and o_err, and force IDLE; flush has priority over every simultaneous event.

Reset
REQ-024 With rst_n low at a clk edge: state IDLE, all FIFOs empty, counters/sum 0, pointer 0, o_in_fifo_is_full 0, o_out_is_empty 1, o_out_vld 0, o_out_front 0, o_busy 0, o_err 0.
REQ-025 Reset mid-operation SHALL discard all in-flight data; no partial result is emitted.

Structure
REQ-026 State enum, LBL_W/pointer-width helper functions and saturation functions SHALL live in shared package rf_pkg.
REQ-027 Input and result FIFOs SHALL be instances of one sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/front).

Verification
REQ-028 Clf, N_DTPS=4: channels push labels {2,2,1,3,2,1}, then fin -> one result 2, o_busy low within 6+2+4+2 cycles.
REQ-029 Rgs, shift 2: pushes {100,-20,40,0} then fin -> result 30; pushes {32767 x4} with shift 0 -> result 32767 (saturated).
REQ-030 Tie: labels {0,3,3,0} -> result 0; label 5 with N_LABELS=4 -> dropped, o_err=1.
REQ-031 Result FIFO full (OUT_DEPTH samples, no pop): next fin holds FSM in PUSH; one pop -> result written next cycle.
REQ-032 Channel 1 pushed IN_DEPTH+1 times back-to-back while FSM in PUSH -> last word dropped, o_err=1; flush mid-ACCUM -> all empties 1, o_err 0, o_busy 0.
